// File: rtl/e_mdu_if.sv
// Request/result bundle between the Execute stage and the multiply/divide unit.
interface e_mdu_if #(
   parameter int unsigned WIDTH = 32
);

   logic             start;
   logic [2:0]       MDUOp;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   // Execute stage side: issues requests, observes busy and HI/LO
   modport master (
      output start,
      output MDUOp,
      output A,
      output B,
      input  busy,
      input  HI,
      input  LO
   );

   // MDU side
   modport slave (
      input  start,
      input  MDUOp,
      input  A,
      input  B,
      output busy,
      output HI,
      output LO
   );

endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// mult/div latch their operands, stay busy for a fixed latency, then commit
// HI/LO on the final edge; mthi/mtlo write in a single cycle without busy.
module e_mdu #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic    clk,
   input logic    reset,
   e_mdu_if.slave bus
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic             state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   // Result datapath, driven only by the latched operand copies
   logic               is_mult;
   logic               is_signed;
   logic [2*WIDTH-1:0] mul_a, mul_b, product;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag;
   logic [WIDTH-1:0]   quotient, remainder;
   logic               div_zero;

   // Multiply and divide results from the latched operands
   always_comb begin
      is_mult   = (op_q == OP_MULT) || (op_q == OP_MULTU);
      is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

      // Sign-extend for mult, zero-extend for multu; one multiplier serves both
      mul_a   = {{WIDTH{is_signed & a_q[WIDTH-1]}}, a_q};
      mul_b   = {{WIDTH{is_signed & b_q[WIDTH-1]}}, b_q};
      product = mul_a * mul_b;

      // Signed divide on magnitudes, then restore signs: quotient truncates
      // toward zero, remainder follows the dividend. The most-negative / -1
      // case falls out naturally as LO = most-negative, HI = 0.
      a_neg     = is_signed & a_q[WIDTH-1];
      b_neg     = is_signed & b_q[WIDTH-1];
      a_mag     = a_neg ? (~a_q + 1'b1) : a_q;
      b_mag     = b_neg ? (~b_q + 1'b1) : b_q;
      div_zero  = (b_q == '0);
      q_mag     = div_zero ? '0 : (a_mag / b_mag);
      r_mag     = div_zero ? '0 : (a_mag % b_mag);
      quotient  = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
      remainder = a_neg ? (~r_mag + 1'b1) : r_mag;
   end

   // Next-state: accept in IDLE, count down in RUN, commit on the last edge
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      if (state_q == ST_IDLE) begin
         if (bus.start) begin
            case (bus.MDUOp)
               OP_MULT, OP_MULTU: begin
                  a_d     = bus.A;
                  b_d     = bus.B;
                  op_d    = bus.MDUOp;
                  cnt_d   = CW'(MULT_CYCLES);
                  state_d = ST_RUN;
               end
               OP_DIV, OP_DIVU: begin
                  a_d     = bus.A;
                  b_d     = bus.B;
                  op_d    = bus.MDUOp;
                  cnt_d   = CW'(DIV_CYCLES);
                  state_d = ST_RUN;
               end
               OP_MTHI: hi_d = bus.A;
               OP_MTLO: lo_d = bus.A;
               default: ;
            endcase
         end
      end else begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            state_d = ST_IDLE;
            if (is_mult) begin
               hi_d = product[2*WIDTH-1:WIDTH];
               lo_d = product[WIDTH-1:0];
            end else if (!div_zero) begin
               // Divide by zero leaves HI/LO untouched
               hi_d = remainder;
               lo_d = quotient;
            end
         end
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.busy = (state_q == ST_RUN);
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

// File: doc/e_mdu.md
# e_mdu

Parametrised multi-cycle multiply/divide unit for the Execute stage of the pipelined MIPS core. It sits beside the combinational ALU and owns the architectural HI/LO registers. It executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo`, and reports `busy` so the hazard unit can stall `mfhi`/`mflo` and further MDU instructions. Latencies are parameters, so the same block serves the course-timing model and faster variants.

## Interface

Parameters:

- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy duration of `mult`/`multu`; legal range ≥1.
- `DIV_CYCLES`, 10: busy duration of `div`/`divu`; legal range ≥1.

Ports:

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; 0 clears all state immediately.
- `start` input 1: request; sampled on a rising edge.
- `MDUOp` input 3: operation code.
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 is reserved and treated as none.
- `A` input WIDTH: rs operand (dividend / multiplicand / mthi-mtlo source).
- `B` input WIDTH: rt operand (divisor / multiplier).
- `busy` output 1: high while a mult/div is in flight.
- `HI` output WIDTH: architectural HI register.
- `LO` output WIDTH: architectural LO register.

## Operation

- **States:** IDLE and RUN. A down-counter `cnt` holds remaining cycles, sized for max(MULT_CYCLES, DIV_CYCLES).
- **Accept rule:** a request is accepted only when `start`=1, the state is IDLE and `MDUOp` is in 1..6. Any other request is ignored with no state change, including any `start` seen in RUN.
- **mthi/mtlo accepted:**
  - `HI` (or `LO`) ← `A` at that edge.
  - State stays IDLE and `busy` stays 0.
- **mult/div accepted:**
  - `A`, `B` and the op are latched, and the result is computed from the latched copies.
  - `cnt` ← MULT_CYCLES or DIV_CYCLES.
  - State → RUN.
- **In RUN:** `cnt` decrements each edge. On the edge where `cnt`=1, `HI`/`LO` load the result and the state returns to IDLE.
- **mult/multu:** full 2·WIDTH product, signed or unsigned. `HI` = upper WIDTH bits, `LO` = lower WIDTH bits.
- **div/divu:** `LO` = quotient, `HI` = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
- **Divide by zero** (both div and divu): runs the full DIV_CYCLES; `HI`/`LO` are left unchanged at completion.
- **Signed overflow** (A = most-negative, B = −1): `LO` = most-negative, `HI` = 0.
- **HI/LO stability:** `HI`/`LO` hold their old values for the whole RUN period. The hazard unit stalls on `busy`, so no stale read leaks.

## Timing

- **Reset values:** `busy`=0, `HI`=0, `LO`=0, state IDLE, `cnt`=0. They take effect asynchronously when `reset` falls and hold until `reset` rises.
- **Accept edge:** mult/div accepted at edge T0.
  - `busy`=1 from just after T0 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - At edge T0+N: `busy`→0, and the new `HI`/`LO` are visible in the same cycle.
- **Back-to-back:** a new `start` at edge T0+N (the completion edge) is ignored, because the state is still RUN when sampled. The earliest next accept is edge T0+N+1.
- **mthi/mtlo:** 1-cycle write; the new value is visible immediately after the accept edge. `busy` is never raised.
- **Reset mid-operation:** the in-flight op is abandoned. No later `HI`/`LO` update occurs, and `busy` falls asynchronously.
- **Operand changes during RUN:** changes on `A`/`B`/`MDUOp` during RUN have no effect.

## Test plan

Bench configuration for all cases: WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10.

- **Reset:**
  - Pulse `reset`=0 mid-cycle → `busy`=0, `HI`=0, `LO`=0 before the next edge.
  - Assert `start` with mult while `reset`=0 → no change.
- **mult:**
  - A=0xFFFFFFFF, B=2 → `busy` high exactly 5 cycles, then `HI`=0xFFFFFFFF, `LO`=0xFFFFFFFE.
  - multu with same operands → `HI`=0x00000001, `LO`=0xFFFFFFFE.
- **div:**
  - A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF.
  - divu A=7, B=2 → `LO`=3, `HI`=1.
- **Boundary divides:**
  - Preload `HI`=0x1234, `LO`=0x5678 via mthi/mtlo, then div by zero → `busy` 10 cycles, `HI`/`LO` unchanged.
  - div 0x80000000 / 0xFFFFFFFF → `LO`=0x80000000, `HI`=0.
- **Ignored requests:**
  - During a mult, pulse `start` with mthi A=0xAAAA at busy cycle 3 and again at the completion edge → both ignored; final `HI` is the product's upper half.
  - Idle mtlo A=0x55 → `LO`=0x55 one edge later, `busy` never 1.
- **Reset mid-div:** drop `reset` at busy cycle 4 → `busy`=0, `HI`=`LO`=0, with no update 6 cycles later. After release, a new multu 3×4 gives `LO`=12.
